// File: rtl/rotate_scheduler.sv
// rotate_scheduler: shares one fixed-point rotation datapath among NUM_REQ
// requesters. A round-robin arbiter picks one valid requester per cycle and
// registers its operands in stage A. The combinational rotate block computes
// the result from stage A. Stage B registers the result and drives the
// response port, which can be back-pressured.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   req_valid  - per-requester request valid   [NUM_REQ]
//   req_ready  - per-requester accept, one-hot or zero [NUM_REQ]
//   req_x/y    - packed operands, requester i at [i*FLOAT_BITS +: FLOAT_BITS]
//   req_sin    - packed sin operands, same packing
//   req_cos    - packed cos operands, same packing
//   resp_valid - result available
//   resp_ready - consumer accepts result
//   resp_id    - requester index of the result
//   resp_x1    - rotated x, signed
//   resp_y1    - rotated y, signed
//   busy       - some pipeline stage holds data
//
// Fixed-point format: FLOAT_BITS total bits with FLOAT_BITS/2 fraction bits.
// Each product is rescaled by an arithmetic right shift and truncated to
// FLOAT_BITS before the two products are combined. Sums wrap.

`ifndef FLOAT_BITS
`define FLOAT_BITS 32
`endif

// rotate: combinational rotation
//   x1 =  x*cos + y*sin
//   y1 = -x*sin + y*cos
module rotate #(
   parameter int FLOAT_BITS = `FLOAT_BITS
) (
   input  logic signed [FLOAT_BITS-1:0] x,
   input  logic signed [FLOAT_BITS-1:0] y,
   input  logic signed [FLOAT_BITS-1:0] sin_val,
   input  logic signed [FLOAT_BITS-1:0] cos_val,
   output logic signed [FLOAT_BITS-1:0] x1,
   output logic signed [FLOAT_BITS-1:0] y1
);
   localparam int FRAC = FLOAT_BITS / 2;

   logic signed [2*FLOAT_BITS-1:0] p_xc;
   logic signed [2*FLOAT_BITS-1:0] p_ys;
   logic signed [2*FLOAT_BITS-1:0] p_xs;
   logic signed [2*FLOAT_BITS-1:0] p_yc;

   assign p_xc = x * cos_val;
   assign p_ys = y * sin_val;
   assign p_xs = x * sin_val;
   assign p_yc = y * cos_val;

   // Each product drops its fraction (floor) and is truncated to operand width.
   assign x1 = FLOAT_BITS'(p_xc >>> FRAC) + FLOAT_BITS'(p_ys >>> FRAC);
   assign y1 = FLOAT_BITS'(p_yc >>> FRAC) - FLOAT_BITS'(p_xs >>> FRAC);
endmodule

module rotate_scheduler #(
   parameter int NUM_REQ    = 7,
   parameter int ID_W       = 3,
   parameter int FLOAT_BITS = `FLOAT_BITS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*FLOAT_BITS-1:0]  req_x,
   input  logic [NUM_REQ*FLOAT_BITS-1:0]  req_y,
   input  logic [NUM_REQ*FLOAT_BITS-1:0]  req_sin,
   input  logic [NUM_REQ*FLOAT_BITS-1:0]  req_cos,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output logic [ID_W-1:0]                resp_id,
   output logic signed [FLOAT_BITS-1:0]   resp_x1,
   output logic signed [FLOAT_BITS-1:0]   resp_y1,
   output logic                           busy
);
   localparam int IDX_W = $clog2(NUM_REQ);

   // Stage A: registered winning operands
   logic                          a_valid;
   logic [ID_W-1:0]               a_id;
   logic signed [FLOAT_BITS-1:0]  a_x, a_y, a_sin, a_cos;

   // Stage B: registered rotation result
   logic                          b_valid;
   logic [ID_W-1:0]               b_id;
   logic signed [FLOAT_BITS-1:0]  b_x1, b_y1;

   // Round-robin state: index of the last requester that actually transferred
   logic [ID_W-1:0]               last_grant;

   logic [NUM_REQ-1:0]            grant;
   logic [ID_W-1:0]               grant_id;
   logic                          found;
   int                            idx;
   logic signed [FLOAT_BITS-1:0]  sel_x, sel_y, sel_sin, sel_cos;
   logic signed [FLOAT_BITS-1:0]  rot_x1, rot_y1;
   logic                          b_load;
   logic                          a_open;
   logic                          a_accept;

   // B empties or drains this cycle -> A may move forward; A moving forward
   // (or being empty) is what lets a new request in, so a drain and an accept
   // in the same cycle never leave a bubble.
   assign b_load   = a_valid & (~b_valid | resp_ready);
   assign a_open   = ~a_valid | b_load;
   assign a_accept = a_open & found;

   // Round-robin search: start one past the last grant, wrap modulo NUM_REQ,
   // and take the first valid requester. The pointer is only moved by an
   // actual transfer, so a requester blocked by back-pressure keeps its turn.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(last_grant) + off) % NUM_REQ;
         if (!found && req_valid[IDX_W'(idx)]) begin
            found                = 1'b1;
            grant[IDX_W'(idx)]   = 1'b1;
            grant_id             = ID_W'(idx);
         end
      end
   end

   // Operand mux selecting the slices of the provisional winner
   always_comb begin
      sel_x   = '0;
      sel_y   = '0;
      sel_sin = '0;
      sel_cos = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_x   = req_x[i*FLOAT_BITS +: FLOAT_BITS];
            sel_y   = req_y[i*FLOAT_BITS +: FLOAT_BITS];
            sel_sin = req_sin[i*FLOAT_BITS +: FLOAT_BITS];
            sel_cos = req_cos[i*FLOAT_BITS +: FLOAT_BITS];
         end
      end
   end

   assign req_ready = a_accept ? grant : '0;

   rotate #(.FLOAT_BITS(FLOAT_BITS)) u_rotate (
      .x       (a_x),
      .y       (a_y),
      .sin_val (a_sin),
      .cos_val (a_cos),
      .x1      (rot_x1),
      .y1      (rot_y1)
   );

   // Pipeline registers. Reset throws away anything in flight and points the
   // arbiter at the last requester so requester 0 is searched first.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_valid    <= 1'b0;
         a_id       <= '0;
         a_x        <= '0;
         a_y        <= '0;
         a_sin      <= '0;
         a_cos      <= '0;
         b_valid    <= 1'b0;
         b_id       <= '0;
         b_x1       <= '0;
         b_y1       <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);
      end else begin
         if (a_accept) begin
            a_id       <= grant_id;
            a_x        <= sel_x;
            a_y        <= sel_y;
            a_sin      <= sel_sin;
            a_cos      <= sel_cos;
            last_grant <= grant_id;
         end
         a_valid <= a_accept | (a_valid & ~b_load);
         if (b_load) begin
            b_id <= a_id;
            b_x1 <= rot_x1;
            b_y1 <= rot_y1;
         end
         b_valid <= b_load | (b_valid & ~resp_ready);
      end
   end

   assign resp_valid = b_valid;
   assign resp_id    = b_id;
   assign resp_x1    = b_x1;
   assign resp_y1    = b_y1;
   assign busy       = a_valid | b_valid;
endmodule

// File: tb/tb_rotate_scheduler.sv
// tb_rotate_scheduler: self-checking bench for rotate_scheduler.
// Table of single-request vectors with hand-computed results, hand-written
// sequences for fairness, back-pressure, reset and pointer wrap, then a
// randomized run against a queue-based reference model.

module tb_rotate_scheduler;
   localparam int N   = 7;
   localparam int W   = 32;
   localparam int IDW = 3;
   localparam int ONE = 65536;

   logic             clk;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_x, req_y, req_sin, req_cos;
   logic             resp_valid;
   logic             resp_ready;
   logic [IDW-1:0]   resp_id;
   logic [W-1:0]     resp_x1, resp_y1;
   logic             busy;

   logic [W-1:0]     op_x[N];
   logic [W-1:0]     op_y[N];
   logic [W-1:0]     op_s[N];
   logic [W-1:0]     op_c[N];

   int checks = 0;
   int passed = 0;

   typedef struct {
      int         id;
      logic [31:0] x, y, s, c, ex1, ey1;
   } vec_t;

   typedef struct {
      int          id;
      logic [31:0] x1, y1;
      int          acc_edge;
   } item_t;

   rotate_scheduler #(.NUM_REQ(N), .ID_W(IDW), .FLOAT_BITS(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_sin    (req_sin),
      .req_cos    (req_cos),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_x1    (resp_x1),
      .resp_y1    (resp_y1),
      .busy       (busy)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack per-requester operands onto the flat request buses
   always_comb begin
      req_x   = '0;
      req_y   = '0;
      req_sin = '0;
      req_cos = '0;
      for (int i = 0; i < N; i++) begin
         req_x[i*W +: W]   = op_x[i];
         req_y[i*W +: W]   = op_y[i];
         req_sin[i*W +: W] = op_s[i];
         req_cos[i*W +: W] = op_c[i];
      end
   end

   // Safety net so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic applyStimulus(input int id, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] s, input logic [31:0] c);
      op_x[id] = x;
      op_y[id] = y;
      op_s[id] = s;
      op_c[id] = c;
      req_valid[id] = 1'b1;
   endtask

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic midCycle;
      #4;
   endtask

   task automatic doReset;
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
   endtask

   task automatic drain(input int n);
      req_valid  = '0;
      resp_ready = 1'b1;
      repeat (n) nextCycle();
   endtask

   // Reference rotation: plain integer arithmetic, each product floored
   // by 2^16 and the results wrapped to 32 bits
   function automatic void rotRef(input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] s, input logic [31:0] c,
                                  output logic [31:0] x1, output logic [31:0] y1);
      longint sx, sy, ss, sc;
      sx = longint'(signed'(x));
      sy = longint'(signed'(y));
      ss = longint'(signed'(s));
      sc = longint'(signed'(c));
      x1 = 32'(((sx * sc) >>> 16) + ((sy * ss) >>> 16));
      y1 = 32'(((sy * sc) >>> 16) - ((sx * ss) >>> 16));
   endfunction

   vec_t  vecs[6];
   item_t q[$];

   initial begin
      int          m_last;
      int          edge_cnt;
      int          gi;
      bit          head_vis;
      bit          can_acc;
      logic [N-1:0] exp_ready;
      logic [31:0] mx1, my1;
      logic [31:0] hold_x1;

      rst        = 1'b1;
      req_valid  = '0;
      resp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         op_x[i] = '0; op_y[i] = '0; op_s[i] = '0; op_c[i] = '0;
      end

      vecs[0] = '{id:2, x:32'(5*ONE), y:32'(-3*ONE), s:32'd0, c:32'(ONE),
                  ex1:32'(5*ONE), ey1:32'(-3*ONE)};
      vecs[1] = '{id:4, x:32'(2*ONE), y:32'(7*ONE), s:32'(ONE), c:32'd0,
                  ex1:32'(7*ONE), ey1:32'(-2*ONE)};
      vecs[2] = '{id:0, x:32'(3*ONE), y:32'(ONE), s:32'd0, c:32'(-ONE),
                  ex1:32'(-3*ONE), ey1:32'(-ONE)};
      vecs[3] = '{id:6, x:32'(ONE), y:32'(ONE), s:32'h0000B505, c:32'h0000B505,
                  ex1:32'h00016A0A, ey1:32'd0};
      vecs[4] = '{id:1, x:32'hFFFFFFFF, y:32'd0, s:32'h00008000, c:32'h00008000,
                  ex1:32'hFFFFFFFF, ey1:32'd1};
      vecs[5] = '{id:3, x:32'h7FFF0000, y:32'h7FFF0000, s:32'(ONE), c:32'(ONE),
                  ex1:32'hFFFE0000, ey1:32'd0};

      // Reset state
      nextCycle();
      nextCycle();
      midCycle();
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_resp_id", resp_id, 0);
      checkOutput("rst_resp_x1", resp_x1, 0);
      checkOutput("rst_resp_y1", resp_y1, 0);
      checkOutput("rst_req_ready", req_ready, 0);
      nextCycle();
      rst = 1'b0;
      nextCycle();

      // Single-request vectors: accept, 2-cycle latency, one-cycle response
      foreach (vecs[v]) begin
         applyStimulus(vecs[v].id, vecs[v].x, vecs[v].y, vecs[v].s, vecs[v].c);
         midCycle();
         checkOutput("vec_req_ready", req_ready, N'(1) << vecs[v].id);
         nextCycle();
         req_valid = '0;
         midCycle();
         checkOutput("vec_lat_not_yet", resp_valid, 0);
         checkOutput("vec_busy", busy, 1);
         nextCycle();
         midCycle();
         checkOutput("vec_resp_valid", resp_valid, 1);
         checkOutput("vec_resp_id", resp_id, vecs[v].id);
         checkOutput("vec_resp_x1", resp_x1, vecs[v].ex1);
         checkOutput("vec_resp_y1", resp_y1, vecs[v].ey1);
         nextCycle();
         midCycle();
         checkOutput("vec_one_cycle", resp_valid, 0);
         checkOutput("vec_idle", busy, 0);
         nextCycle();
      end

      // Fairness: all requesters valid continuously
      doReset();
      for (int i = 0; i < N; i++) applyStimulus(i, 32'(i*ONE), 32'd0, 32'd0, 32'(ONE));
      for (int k = 0; k < 16; k++) begin
         midCycle();
         checkOutput("fair_grant", req_ready, N'(1) << (k % N));
         if (k >= 2) begin
            checkOutput("fair_resp_valid", resp_valid, 1);
            checkOutput("fair_resp_id", resp_id, (k - 2) % N);
            checkOutput("fair_resp_x1", resp_x1, 32'(((k - 2) % N) * ONE));
         end
         nextCycle();
      end
      drain(3);

      // Back-pressure: two accepts, then stall, then drain without bubbles
      doReset();
      resp_ready = 1'b0;
      applyStimulus(0, 32'(ONE), 32'd0, 32'd0, 32'(ONE));
      applyStimulus(1, 32'(2*ONE), 32'd0, 32'd0, 32'(ONE));
      midCycle();
      checkOutput("bp_acc0", req_ready, 7'b0000001);
      nextCycle();
      midCycle();
      checkOutput("bp_acc1", req_ready, 7'b0000010);
      nextCycle();
      midCycle();
      checkOutput("bp_full_ready", req_ready, 0);
      checkOutput("bp_full_id", resp_id, 0);
      hold_x1 = resp_x1;
      checkOutput("bp_full_x1", hold_x1, 32'(ONE));
      for (int k = 0; k < 3; k++) begin
         nextCycle();
         midCycle();
         checkOutput("bp_hold_ready", req_ready, 0);
         checkOutput("bp_hold_valid", resp_valid, 1);
         checkOutput("bp_hold_id", resp_id, 0);
         checkOutput("bp_hold_x1", resp_x1, hold_x1);
      end
      nextCycle();
      resp_ready = 1'b1;
      midCycle();
      checkOutput("bp_rel_id0", resp_id, 0);
      checkOutput("bp_rel_ready", req_ready, 7'b0000001);
      nextCycle();
      midCycle();
      checkOutput("bp_rel_id1", resp_id, 1);
      checkOutput("bp_rel_valid1", resp_valid, 1);
      checkOutput("bp_rel_ready1", req_ready, 7'b0000010);
      nextCycle();
      midCycle();
      checkOutput("bp_resume_id", resp_id, 0);
      checkOutput("bp_resume_x1", resp_x1, 32'(ONE));
      nextCycle();
      drain(3);

      // Reset mid-flight with A and B full
      resp_ready = 1'b0;
      applyStimulus(0, 32'(ONE), 32'd0, 32'd0, 32'(ONE));
      applyStimulus(1, 32'(ONE), 32'd0, 32'd0, 32'(ONE));
      nextCycle();
      nextCycle();
      req_valid = '0;
      midCycle();
      checkOutput("rmf_full_busy", busy, 1);
      checkOutput("rmf_full_valid", resp_valid, 1);
      nextCycle();
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      resp_ready = 1'b1;
      applyStimulus(0, 32'(ONE), 32'd0, 32'd0, 32'(ONE));
      applyStimulus(3, 32'(ONE), 32'd0, 32'd0, 32'(ONE));
      midCycle();
      checkOutput("rmf_resp_valid", resp_valid, 0);
      checkOutput("rmf_busy", busy, 0);
      checkOutput("rmf_req0_wins", req_ready, 7'b0000001);
      nextCycle();
      drain(3);
      midCycle();
      checkOutput("rmf_no_stale", resp_valid, 0);
      nextCycle();

      // Idle gap: 5 then lone 6, pointer wraps to 0
      doReset();
      applyStimulus(5, 32'(ONE), 32'd0, 32'd0, 32'(ONE));
      midCycle();
      checkOutput("gap_grant5", req_ready, 7'b0100000);
      nextCycle();
      req_valid = '0;
      nextCycle();
      nextCycle();
      applyStimulus(6, 32'(ONE), 32'd0, 32'd0, 32'(ONE));
      midCycle();
      checkOutput("gap_grant6", req_ready, 7'b1000000);
      nextCycle();
      req_valid = '0;
      applyStimulus(0, 32'(ONE), 32'd0, 32'd0, 32'(ONE));
      applyStimulus(1, 32'(ONE), 32'd0, 32'd0, 32'(ONE));
      applyStimulus(6, 32'(ONE), 32'd0, 32'd0, 32'(ONE));
      midCycle();
      checkOutput("gap_wrap0", req_ready, 7'b0000001);
      nextCycle();
      req_valid[0] = 1'b0;
      midCycle();
      checkOutput("gap_next1", req_ready, 7'b0000010);
      nextCycle();
      drain(4);

      // Randomized run against the queue model
      doReset();
      m_last   = N - 1;
      edge_cnt = 0;
      q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0)
               applyStimulus(i, $urandom, $urandom, $urandom, $urandom);
         resp_ready = ($urandom_range(0, 3) != 0);
         midCycle();
         head_vis = (q.size() > 0) && (edge_cnt > q[0].acc_edge);
         can_acc  = (q.size() < 2) || (head_vis && resp_ready);
         gi = -1;
         for (int off = 1; off <= N; off++)
            if (gi < 0 && req_valid[(m_last + off) % N]) gi = (m_last + off) % N;
         exp_ready = (can_acc && gi >= 0) ? (N'(1) << gi) : '0;
         checkOutput("rand_req_ready", req_ready, exp_ready);
         checkOutput("rand_resp_valid", resp_valid, head_vis);
         checkOutput("rand_busy", busy, q.size() != 0);
         if (head_vis) begin
            checkOutput("rand_resp_id", resp_id, q[0].id);
            checkOutput("rand_resp_x1", resp_x1, q[0].x1);
            checkOutput("rand_resp_y1", resp_y1, q[0].y1);
         end
         @(posedge clk);
         edge_cnt++;
         if (head_vis && resp_ready) void'(q.pop_front());
         if (exp_ready != 0) begin
            rotRef(op_x[gi], op_y[gi], op_s[gi], op_c[gi], mx1, my1);
            q.push_back('{id:gi, x1:mx1, y1:my1, acc_edge:edge_cnt});
            m_last = gi;
         end
         #1;
         if (exp_ready != 0) req_valid[gi] = 1'b0;
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/rotate_scheduler.md
Name: rotate_scheduler

Overview:
- Shares one fixed-point rotation datapath among NUM_REQ requesters, typically one per tangram piece vertex walker in the render pipeline.
- Arbitrates requests round-robin, registers the winning operands, and applies the rotation x1 = x·cos + y·sin, y1 = −x·sin + y·cos through an internal rotate instance.
- Returns the result with the requester id through a registered, back-pressurable response port.

Parameters:
- NUM_REQ, 7, number of requesters (≥2).
- ID_W, 3, response id width; must satisfy 2^ID_W ≥ NUM_REQ.
- FLOAT_BITS, `FLOAT_BITS, signed fixed-point operand width from the shared math constants header.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_x  in  NUM_REQ*FLOAT_BITS  packed x operands; requester i occupies slice [i*FLOAT_BITS +: FLOAT_BITS].
- req_y  in  NUM_REQ*FLOAT_BITS  packed y operands, same packing.
- req_sin  in  NUM_REQ*FLOAT_BITS  packed sin operands, same packing.
- req_cos  in  NUM_REQ*FLOAT_BITS  packed cos operands, same packing.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_W  index of the requester the result belongs to.
- resp_x1  out  FLOAT_BITS  rotated x, signed.
- resp_y1  out  FLOAT_BITS  rotated y, signed.
- busy  out  1  high while any pipeline stage holds data.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Stage-A and stage-B valid bits clear; resp_valid=0, resp_id=0, resp_x1=0, resp_y1=0, busy=0.
  - Round-robin pointer resets so requester 0 has highest priority.
  - Reset mid-operation discards all in-flight data; no response is issued for it.
- Handshakes:
  - A request transfers when req_valid[i] && req_ready[i] at a clk edge.
  - Requesters hold valid and operands stable until accepted.
  - A response transfers when resp_valid && resp_ready.
- Pipeline:
  - Stage A registers the winning operands and id.
  - The rotate datapath is combinational on the stage-A registers.
  - Stage B registers x1, y1 and id, and drives the resp_* outputs directly.
- Stage advance rules:
  - B loads from A when A is valid and (B is empty or B is draining this cycle).
  - A accepts a new request when A is empty or A advances this cycle.
- Throughput and latency:
  - Sustained throughput is 1 result/clk with resp_ready held high.
  - Latency is 2 clks: accept at edge N gives resp_valid at edge N+2.
- Arbitration:
  - The search starts at last_grant+1 and wraps modulo NUM_REQ.
  - The first valid requester found receives req_ready.
  - req_ready is all-zero when stage A cannot accept, or when no requester is valid.
  - The pointer updates only on an actual transfer. A requester whose ready is withdrawn by back-pressure keeps its priority.
- Back-pressure:
  - With resp_ready=0, B holds its outputs stable; at most 2 requests are held (A and B).
  - A further request is then not accepted; req_ready stays 0.
- Simultaneous events: a response drain and a request accept in the same cycle are both honoured, with no bubble.
- Arithmetic:
  - Products and truncation are exactly those of the shared rotate/matrix_multiply datapath. The scheduler passes them through unchanged.
  - Signed two's-complement values; overflow wraps.
- busy = A valid | B valid.

Test Plan:
- Identity: req 2 with x=5·ONE, y=−3·ONE, sin=0, cos=ONE, resp_ready=1 → 2 clks later resp_valid=1, id=2, x1=5·ONE, y1=−3·ONE, for one cycle.
- Quarter turn: sin=ONE, cos=0, x=2·ONE, y=7·ONE → x1=7·ONE, y1=−2·ONE.
- Fairness: all 7 requesters valid continuously → grant order 0,1,2,3,4,5,6,0,… with one grant per clk and resp_id following the same order 2 clks behind.
- Back-pressure:
  - Hold resp_ready=0 with requesters 0 and 1 valid → exactly 2 accepts, then req_ready=0 and resp outputs stable.
  - Release resp_ready → ids 0 then 1 drain on consecutive clks, then accepts resume.
- Reset mid-flight: assert rst for 1 clk while A and B are full → next cycle resp_valid=0, busy=0, and requester 0 wins the next contention against requester 3.
- Idle gaps: a lone request from requester 6 after requester 5 was last granted → granted immediately, pointer wraps and next priority is requester 0.
